// File: rtl/beam_sort_pkg.sv
`default_nettype none
// ============================================================================
// Module      : beam_sort_pkg
// Description : Shared constants, types and helpers for the beam power
//               accumulate-and-rank block (beam_power_sort, beam_pwr_acc).
//               Contents: beam/block geometry, beam index type, ranking
//               FSM state encoding, identity-order helper.
// Revision    : 1.0 - initial release
// ============================================================================
package beam_sort_pkg;

    localparam int NUM_BEAMS     = 64;
    localparam int NUM_BLK       = 4;
    localparam int BEAMS_PER_BLK = 16;
    localparam int IDX_W         = 8;

    typedef logic [IDX_W-1:0] beam_idx_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } sort_state_e;

    // Slot i holds beam i; this is the power-on ranking and also what a
    // symbol of all-equal powers produces under the lower-index tie rule.
    function automatic logic [BEAMS_PER_BLK-1:0][IDX_W-1:0] identity_order();
        logic [BEAMS_PER_BLK-1:0][IDX_W-1:0] v;
        for (int s = 0; s < BEAMS_PER_BLK; s++) begin
            v[s] = IDX_W'(s);
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/beam_pwr_acc.sv
`default_nettype none
// ============================================================================
// Module      : beam_pwr_acc
// Description : 64 saturating per-beam power accumulators fed in blocks of
//               16 beams, plus the symbol-end snapshot array.
//               Optional macro BEAM_PWR_DECAY_EN: at symbol end the
//               accumulators decay (acc - acc>>DECAY_SHIFT) instead of
//               clearing.
// Ports       : i_clk, i_reset_n     clock, async active-low reset
//               i_pwr_vld/i_pwr_eop  beat valid / last beat of symbol
//               i_blk_idx            block of 16 beams addressed by the beat
//               i_pwr_data           16 packed unsigned power samples
//               i_snap_en            snapshot may be overwritten this edge
//               o_snap               64 snapshot values for the ranker
// Revision    : 1.0 - initial release
// ============================================================================
module beam_pwr_acc
    import beam_sort_pkg::*;
#(
    parameter int PWR_WIDTH   = 32,
    parameter int ACC_WIDTH   = 40,
    parameter int DECAY_SHIFT = 2
) (
    input  logic                                      i_clk,
    input  logic                                      i_reset_n,
    input  logic                                      i_pwr_vld,
    input  logic                                      i_pwr_eop,
    input  logic [$clog2(NUM_BLK)-1:0]                i_blk_idx,
    input  logic [BEAMS_PER_BLK-1:0][PWR_WIDTH-1:0]   i_pwr_data,
    input  logic                                      i_snap_en,
    output logic [NUM_BEAMS-1:0][ACC_WIDTH-1:0]       o_snap
);

    // Symbol-end retention: acc - (acc >> SHIFT). A shift of zero removes
    // the whole value, which is exactly the per-symbol clear.
`ifdef BEAM_PWR_DECAY_EN
    localparam int END_SHIFT = DECAY_SHIFT;
`else
    localparam int END_SHIFT = DECAY_SHIFT * 0;
`endif

    logic w_sym_end;
    assign w_sym_end = i_pwr_vld & i_pwr_eop;

    for (genvar b = 0; b < NUM_BEAMS; b++) begin : g_beam
        localparam int BLK  = b / BEAMS_PER_BLK;
        localparam int LANE = b % BEAMS_PER_BLK;

        logic                 w_hit;
        logic [ACC_WIDTH:0]   w_add;
        logic [ACC_WIDTH-1:0] w_sum;
        logic [ACC_WIDTH-1:0] w_end_val;
        logic [ACC_WIDTH-1:0] r_acc;
        logic [ACC_WIDTH-1:0] r_snap;

        assign w_hit = i_pwr_vld && (i_blk_idx == ($clog2(NUM_BLK))'(BLK));

        // One spare carry bit detects overflow; clamp to all-ones.
        assign w_add = {1'b0, r_acc}
                     + (w_hit ? {{(ACC_WIDTH + 1 - PWR_WIDTH){1'b0}}, i_pwr_data[LANE]}
                              : {(ACC_WIDTH + 1){1'b0}});
        assign w_sum     = w_add[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : w_add[ACC_WIDTH-1:0];
        assign w_end_val = w_sum - (w_sum >> END_SHIFT);

        always_ff @(posedge i_clk or negedge i_reset_n) begin
            if (!i_reset_n) begin
                r_acc  <= '0;
                r_snap <= '0;
            end else begin
                r_acc <= w_sym_end ? w_end_val : w_sum;
                // The eop beat's own data is part of the captured sum.
                if (w_sym_end && i_snap_en) begin
                    r_snap <= w_sum;
                end
            end
        end

        assign o_snap[b] = r_snap;
    end

endmodule
`default_nettype wire

// File: rtl/beam_power_sort.sv
`default_nettype none
// ============================================================================
// Module      : beam_power_sort
// Description : Accumulates per-beam power over a symbol for 64 beams and at
//               symbol end ranks them, emitting the 16 strongest beam
//               indices (slot 0 strongest) with a one-cycle strobe.
//               Optional macro BEAM_PWR_DECAY_EN: IIR decay of the
//               accumulators across symbols instead of clearing.
// Ports       : i_clk, i_reset_n     clock, async active-low reset
//               i_pwr_vld/i_pwr_eop  power beat valid / last beat of symbol
//               i_blk_idx            beam block (blk*16 .. blk*16+15)
//               i_pwr_data           16 packed powers of the block
//               o_sort_idx           ranked beam indices, held between strobes
//               o_sort_sop           one-cycle strobe, o_sort_idx updated
//               o_busy               ranking in progress
//               o_overrun            symbol end arrived while not idle
// Revision    : 1.0 - initial release
// ============================================================================
module beam_power_sort
    import beam_sort_pkg::*;
#(
    parameter int PWR_WIDTH   = 32,
    parameter int ACC_WIDTH   = 40,
    parameter int NUM_SEL     = 16,
    parameter int DECAY_SHIFT = 2
) (
    input  logic                                    i_clk,
    input  logic                                    i_reset_n,
    input  logic                                    i_pwr_vld,
    input  logic                                    i_pwr_eop,
    input  logic [1:0]                              i_blk_idx,
    input  logic [BEAMS_PER_BLK-1:0][PWR_WIDTH-1:0] i_pwr_data,
    output logic [NUM_SEL-1:0][IDX_W-1:0]           o_sort_idx,
    output logic                                    o_sort_sop,
    output logic                                    o_busy,
    output logic                                    o_overrun
);

    localparam int SCAN_W = $clog2(NUM_BEAMS);
    localparam int PASS_W = $clog2(NUM_SEL);

    logic [NUM_BEAMS-1:0][ACC_WIDTH-1:0] w_snap;
    logic                                w_sym_end;

    sort_state_e                    r_state;
    logic [SCAN_W-1:0]              r_scan;
    logic [PASS_W-1:0]              r_pass;
    logic [SCAN_W-1:0]              r_best_idx;
    logic                           r_best_vld;
    logic [ACC_WIDTH-1:0]           r_best_pwr;
    logic [NUM_BEAMS-1:0]           r_mask;
    logic [NUM_SEL-1:0][IDX_W-1:0]  r_result;

    logic                           w_take;
    logic [SCAN_W-1:0]              w_win_idx;

    assign w_sym_end = i_pwr_vld & i_pwr_eop;

    beam_pwr_acc #(
        .PWR_WIDTH   (PWR_WIDTH),
        .ACC_WIDTH   (ACC_WIDTH),
        .DECAY_SHIFT (DECAY_SHIFT)
    ) u_acc (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_pwr_vld  (i_pwr_vld),
        .i_pwr_eop  (i_pwr_eop),
        .i_blk_idx  (i_blk_idx),
        .i_pwr_data (i_pwr_data),
        .i_snap_en  (r_state == IDLE),
        .o_snap     (w_snap)
    );

    // Strictly-greater replacement with an ascending scan keeps the lowest
    // index on ties. An empty running best accepts any unmasked beam, so
    // all-zero powers still fill every slot.
    assign w_take    = !r_mask[r_scan]
                    && (!r_best_vld || (w_snap[r_scan] > r_best_pwr));
    assign w_win_idx = w_take ? r_scan : r_best_idx;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= IDLE;
            r_scan     <= '0;
            r_pass     <= '0;
            r_best_idx <= '0;
            r_best_vld <= 1'b0;
            r_best_pwr <= '0;
            r_mask     <= '0;
            r_result   <= identity_order();
            o_sort_idx <= identity_order();
            o_sort_sop <= 1'b0;
            o_busy     <= 1'b0;
            o_overrun  <= 1'b0;
        end else begin
            o_sort_sop <= 1'b0;
            // Registered copy of the state: high for exactly the 1024 scan
            // cycles, one edge behind the state itself.
            o_busy     <= (r_state == SORT);
            o_overrun  <= w_sym_end && (r_state != IDLE);

            case (r_state)
                IDLE: begin
                    if (w_sym_end) begin
                        r_state    <= SORT;
                        r_scan     <= '0;
                        r_pass     <= '0;
                        r_best_vld <= 1'b0;
                    end
                end

                SORT: begin
                    r_scan <= r_scan + 1'b1;
                    if (w_take) begin
                        r_best_idx <= r_scan;
                        r_best_pwr <= w_snap[r_scan];
                        r_best_vld <= 1'b1;
                    end
                    if (r_scan == SCAN_W'(NUM_BEAMS - 1)) begin
                        r_result[r_pass]  <= IDX_W'(w_win_idx);
                        r_mask[w_win_idx] <= 1'b1;
                        r_best_idx        <= '0;
                        r_best_pwr        <= '0;
                        r_best_vld        <= 1'b0;
                        r_pass            <= r_pass + 1'b1;
                        if (r_pass == PASS_W'(NUM_SEL - 1)) begin
                            r_state <= DONE;
                        end
                    end
                end

                DONE: begin
                    o_sort_idx <= r_result;
                    o_sort_sop <= 1'b1;
                    r_mask     <= '0;
                    r_state    <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_beam_power_sort.sv
`default_nettype none
// ============================================================================
// Module      : tb_beam_power_sort
// Description : Self-checking bench for beam_power_sort. A reference model
//               tracks accumulation, symbol acceptance and the expected
//               ranking (full sort by power, lower index on ties); a compare
//               process checks every output each cycle. Directed scenarios
//               add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_beam_power_sort;

    localparam int  PW   = 32;
    localparam int  AW   = 40;
    localparam int  DS   = 2;
    localparam longint unsigned MAXV = (64'd1 << AW) - 64'd1;
    localparam int  LAT  = 1025;

    logic              i_clk = 1'b0;
    logic              i_reset_n = 1'b0;
    logic              i_pwr_vld = 1'b0;
    logic              i_pwr_eop = 1'b0;
    logic [1:0]        i_blk_idx = 2'd0;
    logic [15:0][31:0] i_pwr_data = '0;
    logic [15:0][7:0]  o_sort_idx;
    logic              o_sort_sop;
    logic              o_busy;
    logic              o_overrun;

    beam_power_sort #(
        .PWR_WIDTH   (PW),
        .ACC_WIDTH   (AW),
        .NUM_SEL     (16),
        .DECAY_SHIFT (DS)
    ) dut (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_pwr_vld  (i_pwr_vld),
        .i_pwr_eop  (i_pwr_eop),
        .i_blk_idx  (i_blk_idx),
        .i_pwr_data (i_pwr_data),
        .o_sort_idx (o_sort_idx),
        .o_sort_sop (o_sort_sop),
        .o_busy     (o_busy),
        .o_overrun  (o_overrun)
    );

    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;
    int ovr_seen = 0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    longint unsigned m_acc [64];
    longint unsigned m_snap[64];
    logic [7:0]      exp_idx [16];
    logic [7:0]      exp_next[16];
    int              m_cyc = 0;
    int              m_E = 0;
    bit              m_have = 0;
    int              m_ovr_at = -1;

    task automatic model_reset();
        for (int b = 0; b < 64; b++) begin
            m_acc[b]  = 0;
            m_snap[b] = 0;
        end
        for (int s = 0; s < 16; s++) exp_idx[s] = 8'(s);
        m_have   = 0;
        m_ovr_at = -1;
    endtask

    // Full ordering of all 64 beams: higher power first, lower index first
    // among equals; the first 16 are the expected ranking.
    task automatic rank();
        int ord[64];
        int t;
        for (int i = 0; i < 64; i++) ord[i] = i;
        for (int i = 1; i < 64; i++) begin
            for (int j = i; j > 0; j--) begin
                if (m_snap[ord[j]] > m_snap[ord[j-1]]) begin
                    t = ord[j]; ord[j] = ord[j-1]; ord[j-1] = t;
                end
            end
        end
        for (int s = 0; s < 16; s++) exp_next[s] = 8'(ord[s]);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge i_clk or negedge i_reset_n);
            if (!i_reset_n) begin
                model_reset();
            end else begin
                m_cyc++;
                if (m_have && m_cyc == m_E + LAT) begin
                    for (int s = 0; s < 16; s++) exp_idx[s] = exp_next[s];
                end
                if (i_pwr_vld) begin
                    for (int k = 0; k < 16; k++) begin
                        int b;
                        longint unsigned sum;
                        b   = int'(i_blk_idx) * 16 + k;
                        sum = m_acc[b] + longint'(i_pwr_data[k]);
                        m_acc[b] = (sum > MAXV) ? MAXV : sum;
                    end
                    if (i_pwr_eop) begin
                        if (!m_have || m_cyc > m_E + LAT) begin
                            for (int b = 0; b < 64; b++) m_snap[b] = m_acc[b];
                            rank();
                            m_E    = m_cyc;
                            m_have = 1;
                        end else begin
                            m_ovr_at = m_cyc;
                        end
                        for (int b = 0; b < 64; b++) begin
`ifdef BEAM_PWR_DECAY_EN
                            m_acc[b] = m_acc[b] - (m_acc[b] >> DS);
`else
                            m_acc[b] = 0;
`endif
                        end
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge i_clk);
            if (i_reset_n) begin
                logic [127:0] e;
                e = '0;
                for (int s = 0; s < 16; s++) e[s*8 +: 8] = exp_idx[s];
                check("sort_idx", o_sort_idx, e);
                check("sort_sop", o_sort_sop, m_have && (m_cyc == m_E + LAT));
                check("busy", o_busy, m_have && (m_cyc >= m_E + 1) && (m_cyc <= m_E + LAT - 1));
                check("overrun", o_overrun, m_ovr_at == m_cyc);
                if (o_overrun) ovr_seen++;
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [31:0] pat_pwr(input int pat, input int b);
        case (pat)
            0:       return 32'(b + 1);
            1:       return 32'd5;
            2:       return (b >= 10 && b <= 25) ? 32'd100 : 32'd1;
            3:       return 32'(1000 * (b + 1));
            default: return (b >= 32 && b <= 47) ? 32'd200 : 32'(b);
        endcase
    endfunction

    task automatic drive_beat(input logic [1:0] blk, input logic [15:0][31:0] d, input logic eop);
        @(negedge i_clk);
        i_pwr_vld  = 1'b1;
        i_pwr_eop  = eop;
        i_blk_idx  = blk;
        i_pwr_data = d;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge i_clk);
            i_pwr_vld = 1'b0;
            i_pwr_eop = 1'b0;
        end
    endtask

    task automatic send_symbol(input int pat);
        logic [15:0][31:0] d;
        for (int blk = 0; blk < 4; blk++) begin
            for (int k = 0; k < 16; k++) d[k] = pat_pwr(pat, blk * 16 + k);
            drive_beat(2'(blk), d, blk == 3);
        end
    endtask

    // Counts negedges from the eop beat's drive edge until the strobe.
    task automatic wait_sop(output int n);
        bit found;
        found = 0;
        n = 0;
        while (n < 1500 && !found) begin
            @(negedge i_clk);
            i_pwr_vld = 1'b0;
            i_pwr_eop = 1'b0;
            n++;
            if (o_sort_sop) found = 1;
        end
        if (!found) check("sop_timeout", 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_reset_n = 1'b0;
        i_pwr_vld = 1'b0;
        i_pwr_eop = 1'b0;
        repeat (3) @(negedge i_clk);
        i_reset_n = 1'b1;
    endtask

    initial begin
        int n;
        int ovr0;
        logic [15:0][31:0] d;

        repeat (3) @(negedge i_clk);
        i_reset_n = 1'b1;

        // 1: quiet after reset
        idle(40);
        check("reset_idx", o_sort_idx, 128'h0f0e0d0c0b0a09080706050403020100);
        check("reset_busy", o_busy, 1'b0);

        // 2: power of beam b = b+1
        send_symbol(0);
        wait_sop(n);
        check("latency", n, LAT + 1);
        check("ramp_idx", o_sort_idx, 128'h303132333435363738393a3b3c3d3e3f);
        idle(3);

        // 3: all equal
        do_reset();
        send_symbol(1);
        wait_sop(n);
        check("equal_idx", o_sort_idx, 128'h0f0e0d0c0b0a09080706050403020100);

        // 4: saturation of beam 7; beam 20 sits just below 2^40 so a wrap
        // of beam 7 would hand it slot 0.
        do_reset();
        for (int k = 0; k < 16; k++) d[k] = (k == 7) ? 32'hffff_ffff : 32'd1;
        for (int i = 0; i < 400; i++) drive_beat(2'd0, d, 1'b0);
        for (int k = 0; k < 16; k++) d[k] = (k == 4) ? 32'hffff_ffff : 32'd0;
        for (int i = 0; i < 256; i++) drive_beat(2'd1, d, i == 255);
        wait_sop(n);
        check("sat_slot0", o_sort_idx[0], 8'd7);
        check("sat_slot1", o_sort_idx[1], 8'd20);
        check("sat_slot2", o_sort_idx[2], 8'd0);

        // 5: overrun 300 cycles after the first eop
        do_reset();
        ovr0 = ovr_seen;
        send_symbol(2);
        idle(296);
        send_symbol(0);
        wait_sop(n);
        check("ovr_first_idx", o_sort_idx, 128'h19181716151413121110_0f0e0d0c0b0a);
        check("ovr_count", ovr_seen - ovr0, 1);
        idle(5);
        send_symbol(3);
        wait_sop(n);
        check("ovr_third_idx", o_sort_idx, 128'h303132333435363738393a3b3c3d3e3f);

        // 6: asynchronous reset in the middle of a sort
        idle(3);
        send_symbol(0);
        idle(500);
        #2 i_reset_n = 1'b0;
        #1;
        check("async_idx", o_sort_idx, 128'h0f0e0d0c0b0a09080706050403020100);
        check("async_busy", o_busy, 1'b0);
        check("async_sop", o_sort_sop, 1'b0);
        check("async_ovr", o_overrun, 1'b0);
        repeat (3) @(negedge i_clk);
        i_reset_n = 1'b1;
        idle(5);
        send_symbol(4);
        wait_sop(n);
        check("post_reset_idx", o_sort_idx, 128'h2f2e2d2c2b2a29282726252423222120);
        idle(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
